invoke_unit: RTL and testbench

//  Method-call sequencer beside control: runs INVOKESTATIC and RETURN as multi-cycle ops.

---
 rtl/invoke_unit.sv | 198 +++++++++++++++++++
 tb/tb_invoke_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invoke_unit.sv
// Method-call sequencer: runs INVOKESTATIC (header fetch, frame push, argument moves, jump)
// and RETURN (frame pop, pc/base restore) as multi-cycle operations beside the control unit.
module invoke_unit #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 32,
  parameter int LVA_AW = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              invoke,
  input  logic [15:0]       method_idx,
  input  logic              ret,
  input  logic [PC_W-1:0]   ret_pc,
  output logic              data_req,
  output logic [15:0]       data_index,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              pop_req,
  input  logic              pop_valid,
  input  logic [DATA_W-1:0] pop_data,
  output logic              lva_we,
  output logic [LVA_AW-1:0] lva_addr,
  output logic [DATA_W-1:0] lva_wdata,
  input  logic              lva_done,
  output logic [LVA_AW-1:0] lva_base,
  output logic              pc_load,
  output logic [PC_W-1:0]   new_pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = ((LVA_AW > 8) ? LVA_AW : 8) + 2;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, POP, WRITE, JUMP, RET} state_t;

  state_t            state, state_nxt;
  logic [15:0]       idx_q;
  logic [PC_W-1:0]   ret_pc_q;
  logic [DATA_W-1:0] hdr_q;
  logic [DATA_W-1:0] arg_q;
  logic [7:0]        cur_locals;
  logic [7:0]        arg_cnt;
  logic [CNT_W-1:0]  count;

  logic [PC_W-1:0]   rpc_stk    [DEPTH];
  logic [LVA_AW-1:0] base_stk   [DEPTH];
  logic [7:0]        locals_stk [DEPTH];

  logic [7:0]        max_locals, nargs;
  logic [SUM_W-1:0]  nb_sum;
  logic              ovf;
  logic [PTR_W-1:0]  push_idx, top_idx;
  logic              stk_empty;

  // Frame fits only if the stack has room, the new frame ends inside the LVA,
  // and every argument has a local slot to land in.
  function automatic logic frame_overflow(input logic [CNT_W-1:0] cnt,
                                          input logic [SUM_W-1:0] nb,
                                          input logic [7:0]       ml,
                                          input logic [7:0]       na);
    return (cnt == CNT_W'(DEPTH)) ||
           ((nb + SUM_W'(ml)) > (SUM_W'(1) << LVA_AW)) ||
           (na > ml);
  endfunction

  // Arguments pop in reverse order: the first pop is the last argument.
  function automatic logic [LVA_AW-1:0] arg_addr(input logic [LVA_AW-1:0] base,
                                                 input logic [7:0]        na,
                                                 input logic [7:0]        j);
    return base + LVA_AW'(na - 8'd1 - j);
  endfunction

  assign max_locals = hdr_q[23:16];
  assign nargs      = hdr_q[31:24];
  assign nb_sum     = SUM_W'(lva_base) + SUM_W'(cur_locals);
  assign ovf        = frame_overflow(count, nb_sum, max_locals, nargs);
  assign push_idx   = PTR_W'(count);
  assign top_idx    = PTR_W'(count - CNT_W'(1));
  assign stk_empty  = (count == '0);

  always_comb begin
    state_nxt  = state;
    data_req   = 1'b0;
    pop_req    = 1'b0;
    lva_we     = 1'b0;
    pc_load    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    new_pc     = '0;
    data_index = '0;
    lva_addr   = '0;
    lva_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (invoke)   state_nxt = FETCH;
        else if (ret) state_nxt = RET;
      end
      FETCH: begin
        data_req   = 1'b1;
        data_index = idx_q;
        if (data_valid) state_nxt = CHECK;
      end
      CHECK: begin
        if (ovf) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else if (nargs != 8'd0) begin
          state_nxt = POP;
        end else begin
          state_nxt = JUMP;
        end
      end
      POP: begin
        pop_req = 1'b1;
        if (pop_valid) state_nxt = WRITE;
      end
      WRITE: begin
        lva_we    = 1'b1;
        lva_addr  = arg_addr(lva_base, nargs, arg_cnt);
        lva_wdata = arg_q;
        if (lva_done) state_nxt = (arg_cnt == nargs - 8'd1) ? JUMP : POP;
      end
      JUMP: begin
        pc_load   = 1'b1;
        done      = 1'b1;
        new_pc    = PC_W'(hdr_q[15:0]);
        state_nxt = IDLE;
      end
      RET: begin
        if (stk_empty) begin
          err = 1'b1;
        end else begin
          pc_load = 1'b1;
          done    = 1'b1;
          new_pc  = rpc_stk[top_idx];
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Control state: FSM, frame count, current frame base/size, argument counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      lva_base   <= '0;
      cur_locals <= '0;
      arg_cnt    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        CHECK: begin
          if (!ovf) begin
            count      <= count + CNT_W'(1);
            lva_base   <= nb_sum[LVA_AW-1:0];
            cur_locals <= max_locals;
            arg_cnt    <= '0;
          end
        end
        WRITE: begin
          if (lva_done) arg_cnt <= arg_cnt + 8'd1;
        end
        RET: begin
          if (!stk_empty) begin
            count      <= count - CNT_W'(1);
            lva_base   <= base_stk[top_idx];
            cur_locals <= locals_stk[top_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // Data capture and frame storage; contents are only meaningful under the control state
  always_ff @(posedge clk) begin
    if (state == IDLE && invoke) begin
      idx_q    <= method_idx;
      ret_pc_q <= ret_pc;
    end
    if (state == FETCH && data_valid) hdr_q <= data_in;
    if (state == POP && pop_valid)    arg_q <= pop_data;
    if (state == CHECK && !ovf) begin
      rpc_stk[push_idx]    <= ret_pc_q;
      base_stk[push_idx]   <= lva_base;
      locals_stk[push_idx] <= cur_locals;
    end
  end

endmodule

// File: tb/tb_invoke_unit.sv
// Randomised bench for invoke_unit: handshake responders with programmable delays and a
// frame-stack reference model built from the call/return rules.
module tb_invoke_unit;
  localparam int PC_W   = 16;
  localparam int DATA_W = 32;
  localparam int LVA_AW = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              invoke = 1'b0;
  logic [15:0]       method_idx = '0;
  logic              ret = 1'b0;
  logic [PC_W-1:0]   ret_pc = '0;
  logic              data_req;
  logic [15:0]       data_index;
  logic              data_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              pop_req;
  logic              pop_valid = 1'b0;
  logic [DATA_W-1:0] pop_data = '0;
  logic              lva_we;
  logic [LVA_AW-1:0] lva_addr;
  logic [DATA_W-1:0] lva_wdata;
  logic              lva_done = 1'b0;
  logic [LVA_AW-1:0] lva_base;
  logic              pc_load;
  logic [PC_W-1:0]   new_pc;
  logic              busy, done, err;

  invoke_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .LVA_AW(LVA_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .invoke(invoke), .method_idx(method_idx), .ret(ret),
    .ret_pc(ret_pc), .data_req(data_req), .data_index(data_index), .data_valid(data_valid),
    .data_in(data_in), .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .lva_we(lva_we), .lva_addr(lva_addr), .lva_wdata(lva_wdata), .lva_done(lva_done),
    .lva_base(lva_base), .pc_load(pc_load), .new_pc(new_pc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] tb_args [0:255];

  typedef struct {
    int rpc;
    int base;
    int locals;
  } frame_t;
  frame_t fq[$];
  int m_base = 0;
  int m_locals = 0;

  // observations from the last operation
  int          o_err, o_pcl, o_done, o_lat;
  logic [15:0] o_newpc;
  bit          o_drop, o_timeout, o_badidx;
  logic [86:0] o_rst_outs;
  // expectations for the last operation
  bit          e_err;
  logic [15:0] e_pc;
  int          e_lat, e_nb;
  logic [15:0] last_rpc;
  bit          g_noise = 1'b0;
  bit          g_both = 1'b0;

  logic [63:0] got, exp;

  task automatic model_op(input bit is_ret, input logic [31:0] hdr, input logic [15:0] rpc,
                          input int dd, input int pd, input int ld,
                          output bit x_err, output logic [15:0] x_pc, output int x_lat,
                          output int x_nb);
    frame_t f;
    int na, ml;
    x_err = 1'b0; x_pc = '0; x_lat = -1; x_nb = 0;
    if (is_ret) begin
      if (fq.size() == 0) x_err = 1'b1;
      else begin
        f = fq.pop_back();
        x_pc = 16'(f.rpc); m_base = f.base; m_locals = f.locals; x_lat = 1;
      end
    end else begin
      na = int'(hdr[31:24]);
      ml = int'(hdr[23:16]);
      x_nb = m_base + m_locals;
      if (fq.size() == DEPTH || x_nb + ml > 256 || na > ml) x_err = 1'b1;
      else begin
        f.rpc = int'(rpc); f.base = m_base; f.locals = m_locals;
        fq.push_back(f);
        m_base = x_nb % 256; m_locals = ml;
        x_pc = hdr[15:0];
        x_lat = 4 + (dd - 1) + na * (2 + pd + ld);
      end
    end
  endtask

  task automatic drive_op(input bit is_ret, input logic [15:0] idx, input logic [15:0] rpc,
                          input logic [31:0] hdr, input int dd, input int pd, input int ld,
                          input bit abort);
    int dcnt = 0, pcnt = 0, lcnt = 0, pidx;
    bit dpend = 0, ppend = 0, lpend = 0, fin = 0;
    pidx = int'(hdr[31:24]) - 1;
    o_err = 0; o_pcl = 0; o_done = 0; o_lat = -1; o_newpc = '0;
    o_drop = 0; o_timeout = 0; o_badidx = 0; o_rst_outs = '1;
    @(negedge clk);
    if (is_ret) ret = 1'b1;
    else begin invoke = 1'b1; ret = g_both; method_idx = idx; ret_pc = rpc; end
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      invoke = 1'b0; ret = 1'b0;
      method_idx = 16'($urandom); ret_pc = 16'($urandom);
      data_valid = 1'b0; pop_valid = 1'b0; lva_done = 1'b0;
      if (pc_load) begin o_pcl++; o_newpc = new_pc; o_lat = cyc; end
      if (done) o_done++;
      if (err) o_err++;
      if (data_req && data_index !== idx) o_badidx = 1;
      if ((dpend && !data_req) || (ppend && !pop_req) || (lpend && !lva_we)) o_drop = 1;
      if (!busy) fin = 1;
      else if (abort && lva_we) begin
        rst_n = 1'b0;
        #1;
        o_rst_outs = {busy, done, err, pc_load, data_req, pop_req, lva_we, new_pc, lva_base,
                      lva_addr, lva_wdata, data_index};
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1;
      end else begin
        if (g_noise) begin invoke = 1'($urandom_range(0, 1)); ret = 1'($urandom_range(0, 1)); end
        if (data_req) begin
          dcnt++; dpend = 1;
          if (dcnt == dd + 1) begin data_valid = 1'b1; data_in = hdr; dpend = 0; dcnt = 0; end
        end else dcnt = 0;
        if (pop_req) begin
          pcnt++; ppend = 1;
          if (pcnt == pd + 1) begin
            pop_valid = 1'b1;
            pop_data = (pidx >= 0) ? tb_args[pidx] : $urandom;
            pidx--; ppend = 0; pcnt = 0;
          end
        end else pcnt = 0;
        if (lva_we) begin
          lcnt++; lpend = 1;
          if (lcnt == ld + 1) begin lva_done = 1'b1; mem[lva_addr] = lva_wdata; lpend = 0; lcnt = 0; end
        end else lcnt = 0;
      end
    end
    if (!fin) o_timeout = 1;
    invoke = 1'b0; ret = 1'b0; data_valid = 1'b0; pop_valid = 1'b0; lva_done = 1'b0;
  endtask

  task automatic exec_op(input bit is_ret, input logic [15:0] idx, input logic [31:0] hdr,
                         input int dd, input int pd, input int ld, input bit abort);
    logic [15:0] rpc;
    rpc = 16'($urandom);
    last_rpc = rpc;
    if (abort) begin
      fq.delete(); m_base = 0; m_locals = 0;
      e_err = 0; e_pc = '0; e_lat = -1; e_nb = 0;
    end else model_op(is_ret, hdr, rpc, dd, pd, ld, e_err, e_pc, e_lat, e_nb);
    if (!is_ret && !e_err && !abort)
      for (int i = 0; i < int'(hdr[31:24]); i++) mem[(e_nb + i) % 256] = ~tb_args[i];
    drive_op(is_ret, idx, rpc, hdr, dd, pd, ld, abort);
    got = {8'(o_err), 8'(o_pcl), 8'(o_done), o_newpc, 16'(o_lat), 8'(lva_base)};
    exp = {8'(e_err), 8'(!e_err), 8'(!e_err), e_pc, 16'(e_lat), 8'(m_base)};
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, err, pc_load, data_req, pop_req, lva_we, new_pc, lva_base} !== '0)
      $display("FAIL reset_held outs=%h want 0",
               {busy, done, err, pc_load, data_req, pop_req, lva_we, new_pc, lva_base});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, pc_load, data_req, pop_req, lva_we, lva_base, data_index} !== '0)
      $display("FAIL reset_release outs=%h want 0",
               {busy, done, err, pc_load, data_req, pop_req, lva_we, lva_base, data_index});
    else passed++;
  endtask

  task automatic test_ret_empty();
    exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
    checks++;
    if ({8'(o_err), 8'(o_pcl), 8'(o_done), lva_base} !== {8'd1, 8'd0, 8'd0, 8'd0})
      $display("FAIL ret_empty err/pcl/done/base got %h want 01000000",
               {8'(o_err), 8'(o_pcl), 8'(o_done), lva_base});
    else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] saved;
    exec_op(1'b0, 16'h0005, 32'h0004_0100, 1, 0, 0, 1'b0);
    saved = last_rpc;
    checks++;
    if ({o_newpc, 16'(o_lat), lva_base, 8'(o_pcl), 8'(o_done)} !== {16'h0100, 16'd4, 8'd0, 8'd1, 8'd1})
      $display("FAIL basic_invoke pc/lat/base/pcl/done got %h want 0100000400 0101",
               {o_newpc, 16'(o_lat), lva_base, 8'(o_pcl), 8'(o_done)});
    else passed++;
    checks++;
    if ({o_badidx, o_drop, o_timeout} !== 3'b000)
      $display("FAIL basic_handshake badidx/drop/timeout got %b want 000", {o_badidx, o_drop, o_timeout});
    else passed++;
    exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
    checks++;
    if ({o_newpc, 16'(o_lat), lva_base, 8'(o_err)} !== {saved, 16'd1, 8'd0, 8'd0})
      $display("FAIL basic_ret pc/lat/base/err got %h want %h",
               {o_newpc, 16'(o_lat), lva_base, 8'(o_err)}, {saved, 16'd1, 8'd0, 8'd0});
    else passed++;
  endtask

  task automatic test_args();
    exec_op(1'b0, 16'h0011, 32'h0005_0200, 1, 0, 0, 1'b0);
    tb_args[0] = 32'hB;
    tb_args[1] = 32'hA;
    exec_op(1'b0, 16'h0012, 32'h0203_0300, 1, 0, 0, 1'b0);
    checks++;
    if ({mem[6], mem[5], lva_base} !== {32'hA, 32'hB, 8'd5})
      $display("FAIL args_lva lva6/lva5/base got %h want %h", {mem[6], mem[5], lva_base},
               {32'hA, 32'hB, 8'd5});
    else passed++;
    checks++;
    if (got !== exp) $display("FAIL args_invoke got %h want %h", got, exp);
    else passed++;
    checks++;
    if (o_lat !== 8) $display("FAIL args_latency got %0d want 8", o_lat);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL args_ret%0d got %h want %h", k, got, exp);
      else passed++;
    end
  endtask

  task automatic test_depth();
    for (int k = 0; k <= DEPTH; k++) begin
      exec_op(1'b0, 16'(k), {8'd0, 8'd1, 16'($urandom)}, 1, 0, 0, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL depth_invoke%0d got %h want %h", k, got, exp);
      else passed++;
    end
    checks++;
    if ({8'(o_err), 8'(o_pcl)} !== {8'd1, 8'd0})
      $display("FAIL depth_overflow err/pcl got %h want 0100", {8'(o_err), 8'(o_pcl)});
    else passed++;
    for (int k = 0; k <= DEPTH; k++) begin
      exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL depth_ret%0d got %h want %h", k, got, exp);
      else passed++;
    end
  endtask

  task automatic test_lva_ovf();
    logic [31:0] hdrs [5];
    hdrs[0] = 32'h00C8_0400;
    hdrs[1] = 32'h0039_0500;
    hdrs[2] = 32'h0302_0600;
    hdrs[3] = 32'h0038_0700;
    hdrs[4] = 32'h0000_0800;
    for (int k = 0; k < 5; k++) begin
      exec_op(1'b0, 16'h0020 + 16'(k), hdrs[k], 1, 0, 0, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL lva_ovf_invoke%0d got %h want %h", k, got, exp);
      else passed++;
      if (k == 1) begin
        checks++;
        if ({8'(o_err), 8'(o_pcl), lva_base} !== {8'd1, 8'd0, 8'd0})
          $display("FAIL lva_ovf_257 err/pcl/base got %h want 010000", {8'(o_err), 8'(o_pcl), lva_base});
        else passed++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL lva_ovf_ret%0d got %h want %h", k, got, exp);
      else passed++;
    end
  endtask

  task automatic test_delays();
    tb_args[0] = $urandom;
    tb_args[1] = $urandom;
    exec_op(1'b0, 16'h0031, 32'h0204_0900, 5, 3, 2, 1'b0);
    checks++;
    if ({got, 16'(o_lat)} !== {exp, 16'd22}) $display("FAIL delay_invoke got %h want %h", {got, 16'(o_lat)}, {exp, 16'd22});
    else passed++;
    checks++;
    if ({mem[(e_nb) % 256], mem[(e_nb + 1) % 256]} !== {tb_args[0], tb_args[1]})
      $display("FAIL delay_lva got %h want %h", {mem[(e_nb) % 256], mem[(e_nb + 1) % 256]},
               {tb_args[0], tb_args[1]});
    else passed++;
    checks++;
    if ({o_drop, o_timeout, o_badidx} !== 3'b000)
      $display("FAIL delay_strobes_held drop/timeout/badidx got %b want 000", {o_drop, o_timeout, o_badidx});
    else passed++;
    exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
    checks++;
    if (got !== exp) $display("FAIL delay_ret got %h want %h", got, exp);
    else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tb_args[i] = $urandom;
    exec_op(1'b0, 16'h0041, 32'h0306_0A00, 1, 0, 3, 1'b1);
    checks++;
    if ({o_rst_outs, 8'(o_pcl), 8'(o_done)} !== '0)
      $display("FAIL reset_mid outs/pcl/done got %h want 0", {o_rst_outs, 8'(o_pcl), 8'(o_done)});
    else passed++;
    tb_args[0] = $urandom;
    exec_op(1'b0, 16'h0042, 32'h0102_0B00, 2, 1, 1, 1'b0);
    checks++;
    if ({got, mem[e_nb % 256]} !== {exp, tb_args[0]})
      $display("FAIL reset_mid_after got %h want %h", {got, mem[e_nb % 256]}, {exp, tb_args[0]});
    else passed++;
    exec_op(1'b1, 16'h0, 32'h0, 1, 0, 0, 1'b0);
    checks++;
    if (got !== exp) $display("FAIL reset_mid_ret got %h want %h", got, exp);
    else passed++;
  endtask

  task automatic test_random();
    int ml, na, dd, pd, ld;
    bit is_ret;
    bit args_ok;
    logic [31:0] hdr;
    g_noise = 1'b1;
    for (int k = 0; k < 60; k++) begin
      is_ret = ($urandom_range(0, 99) < 35);
      g_both = 1'($urandom_range(0, 3) == 0);
      ml = $urandom_range(0, 60);
      na = $urandom_range(0, (ml < 3) ? ml : 3);
      if ($urandom_range(0, 9) == 0) na = ml + 1;
      hdr = {8'(na), 8'(ml), 16'($urandom)};
      for (int i = 0; i < 64; i++) tb_args[i] = $urandom;
      dd = $urandom_range(1, 3); pd = $urandom_range(0, 2); ld = $urandom_range(0, 2);
      exec_op(is_ret, 16'($urandom), hdr, dd, pd, ld, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL rnd_op%0d ret=%0d got %h want %h", k, is_ret, got, exp);
      else passed++;
      if (!is_ret && !e_err) begin
        args_ok = 1'b1;
        for (int i = 0; i < na; i++)
          if (mem[(e_nb + i) % 256] !== tb_args[i]) args_ok = 1'b0;
        checks++;
        if (!args_ok || o_drop || o_badidx || o_timeout)
          $display("FAIL rnd_args%0d ok/drop/badidx/timeout got %b want 1000", k,
                   {args_ok, o_drop, o_badidx, o_timeout});
        else passed++;
      end
    end
    g_noise = 1'b0;
    g_both = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ret_empty();
    test_basic();
    test_args();
    test_depth();
    test_lva_ovf();
    test_delays();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
